// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM states, round constants and GF(2^8) helpers.
// The S-box functions compute the field inverse rather than using a lookup table.
package aes_pkg;

   typedef enum logic [2:0] {IDLE, CAPTURE, KEYEXP, ROUND, DONE} state_t;

   localparam int unsigned NR = 10;

   localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int unsigned i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] p;
      logic [7:0] r;
      p = a;
      r = 8'h01;
      for (int unsigned i = 1; i < 8; i++) begin
         p = gmul(p, p);
         r = gmul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
      return (b << n) | (b >> (8 - n));
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] b;
      b = ginv(a);
      return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
   endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box: inverse affine map followed by field inversion.
module aes_inv_sbox
   import aes_pkg::*;
(
   input  logic [7:0] din,
   output logic [7:0] dout
);

   logic [7:0] t;

   always_comb begin
      t    = rotl8(din, 1) ^ rotl8(din, 3) ^ rotl8(din, 6) ^ 8'h05;
      dout = ginv(t);
   end

endmodule

// File: rtl/aes_inv_core.sv
// Iterative AES-128 decryption: the forward key schedule runs to rk10, then one
// inverse round per clock walks the schedule back down to rk0.
module aes_inv_core
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [127:0] key,
   input  logic [127:0] cyphertext,
   output logic         done,
   output logic [127:0] plaintext
);

   state_t       state;
   logic [3:0]   rnd;
   logic [127:0] rk, ct_reg, data_state;
   logic [7:0]   rc;
   logic [31:0]  w3, sub_out, f0, f1, f2, f3, p1, p2, p3;
   logic [127:0] rk_fwd, rk_prev, isr, isb, ark, imc;

   // Forward and inverse schedule share one SubWord: word 0 of both is
   // w0 ^ SubWord(RotWord(x)) ^ Rcon, only x differs (w3, or w3^w2 going back).
   always_comb begin
      rc      = RCON[rnd + 4'd1];
      w3      = (state == ROUND) ? (rk[31:0] ^ rk[63:32]) : rk[31:0];
      sub_out = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
      f0      = rk[127:96] ^ sub_out ^ {rc, 24'h000000};
      f1      = rk[95:64] ^ f0;
      f2      = rk[63:32] ^ f1;
      f3      = rk[31:0] ^ f2;
      p1      = rk[95:64] ^ rk[127:96];
      p2      = rk[63:32] ^ rk[95:64];
      p3      = rk[31:0] ^ rk[63:32];
      rk_fwd  = {f0, f1, f2, f3};
      rk_prev = {f0, p1, p2, p3};
   end

   assign ark = isb ^ rk_prev;

   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign isr[127-8*(4*c+r) -: 8] = data_state[127-8*(4*((c-r+4)%4)+r) -: 8];
         aes_inv_sbox u_isb (
            .din  (isr[127-8*(4*c+r) -: 8]),
            .dout (isb[127-8*(4*c+r) -: 8])
         );
      end
      assign imc[127-32*c -: 8] = gmul(ark[127-32*c -: 8], 8'h0e) ^ gmul(ark[119-32*c -: 8], 8'h0b)
                                ^ gmul(ark[111-32*c -: 8], 8'h0d) ^ gmul(ark[103-32*c -: 8], 8'h09);
      assign imc[119-32*c -: 8] = gmul(ark[127-32*c -: 8], 8'h09) ^ gmul(ark[119-32*c -: 8], 8'h0e)
                                ^ gmul(ark[111-32*c -: 8], 8'h0b) ^ gmul(ark[103-32*c -: 8], 8'h0d);
      assign imc[111-32*c -: 8] = gmul(ark[127-32*c -: 8], 8'h0d) ^ gmul(ark[119-32*c -: 8], 8'h09)
                                ^ gmul(ark[111-32*c -: 8], 8'h0e) ^ gmul(ark[103-32*c -: 8], 8'h0b);
      assign imc[103-32*c -: 8] = gmul(ark[127-32*c -: 8], 8'h0b) ^ gmul(ark[119-32*c -: 8], 8'h0d)
                                ^ gmul(ark[111-32*c -: 8], 8'h09) ^ gmul(ark[103-32*c -: 8], 8'h0e);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         rnd        <= '0;
         rk         <= '0;
         ct_reg     <= '0;
         data_state <= '0;
         done       <= 1'b0;
         plaintext  <= '0;
      end else if (load) begin
         rk     <= key;
         ct_reg <= cyphertext;
         rnd    <= '0;
         done   <= 1'b0;
         state  <= CAPTURE;
      end else begin
         case (state)
            CAPTURE: begin
               rk    <= rk_fwd;
               rnd   <= 4'd1;
               state <= KEYEXP;
            end
            KEYEXP: begin
               rk <= rk_fwd;
               if (rnd == 4'(NR - 1)) begin
                  data_state <= ct_reg ^ rk_fwd;
                  state      <= ROUND;
               end else begin
                  rnd <= rnd + 4'd1;
               end
            end
            ROUND: begin
               rk <= rk_prev;
               if (rnd == '0) begin
                  plaintext <= ark;
                  done      <= 1'b1;
                  state     <= DONE;
               end else begin
                  data_state <= imc;
                  rnd        <= rnd - 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_inv_core.sv
// Scoreboard bench for aes_inv_core against a table-driven AES-128 reference model.
module tb_aes_inv_core;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         load = 1'b0;
   logic [127:0] key = '0;
   logic [127:0] cyphertext = '0;
   logic         done;
   logic [127:0] plaintext;

   typedef struct {
      logic [127:0] pt;
      int           cyc;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail = 0;
   int   cyc = 0;

   bit [7:0] sb_t [256];
   bit [7:0] isb_t [256];

   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

   aes_inv_core dut (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .key        (key),
      .cyphertext (cyphertext),
      .done       (done),
      .plaintext  (plaintext)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   function automatic bit [7:0] gf_mul(input bit [7:0] a, input bit [7:0] b);
      bit [15:0] p;
      p = '0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
      return p[7:0];
   endfunction

   task automatic build_tables();
      bit [7:0] inv, s, cst;
      cst = 8'h63;
      for (int a = 0; a < 256; a++) begin
         inv = '0;
         for (int b = 1; b < 256; b++) if (gf_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
         sb_t[a]  = s;
         isb_t[s] = 8'(a);
      end
   endtask

   function automatic logic [127:0] round_key(input logic [127:0] k, input int n);
      bit [31:0] w [4];
      bit [31:0] t;
      bit [7:0]  rc;
      rc = 8'h01;
      for (int j = 0; j < 4; j++) w[j] = k[127-32*j -: 32];
      for (int r = 1; r <= n; r++) begin
         t = {w[3][23:0], w[3][31:24]};
         t = {sb_t[t[31:24]], sb_t[t[23:16]], sb_t[t[15:8]], sb_t[t[7:0]]} ^ {rc, 24'h0};
         w[0] = w[0] ^ t;
         w[1] = w[1] ^ w[0];
         w[2] = w[2] ^ w[1];
         w[3] = w[3] ^ w[2];
         rc = gf_mul(rc, 8'h02);
      end
      return {w[0], w[1], w[2], w[3]};
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] v, input bit inv);
      logic [127:0] o;
      for (int i = 0; i < 16; i++)
         o[127-8*i -: 8] = inv ? isb_t[v[127-8*i -: 8]] : sb_t[v[127-8*i -: 8]];
      return o;
   endfunction

   function automatic logic [127:0] shift_rows(input logic [127:0] v, input bit inv);
      logic [127:0] o;
      int src;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            src = inv ? (c - r + 4) % 4 : (c + r) % 4;
            o[127-8*(4*c+r) -: 8] = v[127-8*(4*src+r) -: 8];
         end
      return o;
   endfunction

   function automatic logic [127:0] mix_cols(input logic [127:0] v, input logic [31:0] cf);
      logic [127:0] o;
      bit [7:0] acc;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            acc = '0;
            for (int k = 0; k < 4; k++)
               acc = acc ^ gf_mul(cf[31-8*((k-r+4)%4) -: 8], v[127-8*(4*c+k) -: 8]);
            o[127-8*(4*c+r) -: 8] = acc;
         end
      return o;
   endfunction

   function automatic logic [127:0] aes_enc(input logic [127:0] p, input logic [127:0] k);
      logic [127:0] s;
      s = p ^ round_key(k, 0);
      for (int r = 1; r <= 10; r++) begin
         s = shift_rows(sub_bytes(s, 1'b0), 1'b0);
         if (r < 10) s = mix_cols(s, 32'h02030101);
         s = s ^ round_key(k, r);
      end
      return s;
   endfunction

   function automatic logic [127:0] aes_dec(input logic [127:0] c, input logic [127:0] k);
      logic [127:0] s;
      s = c ^ round_key(k, 10);
      for (int r = 9; r >= 0; r--) begin
         s = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ round_key(k, r);
         if (r > 0) s = mix_cols(s, 32'h0e0b0d09);
      end
      return s;
   endfunction

   // ---------------- checking ----------------
   task automatic chk128(input string nm, input logic [127:0] act, input logic [127:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", nm, act, req);
      end
   endtask

   task automatic chkint(input string nm, input int act, input int req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", nm, act, req);
      end
   endtask

   initial begin : monitor
      logic done_q;
      exp_t e;
      done_q = 1'b0;
      forever begin
         @(negedge clk);
         if (done === 1'b1 && done_q !== 1'b1) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_done: done rose at cycle %0d, required no pending run", cyc);
            end else begin
               e = sb.pop_front();
               chk128("plaintext", plaintext, e.pt);
               chkint("done_edge", cyc, e.cyc);
            end
         end
         done_q = done;
      end
   end

   // ---------------- stimulus ----------------
   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic start_run(input logic [127:0] k, input logic [127:0] c,
                            input logic [127:0] exp_pt, input int hold);
      exp_t e;
      @(negedge clk);
      key        = k;
      cyphertext = c;
      load       = 1'b1;
      repeat (hold) @(negedge clk);
      load   = 1'b0;
      e.pt   = exp_pt;
      e.cyc  = cyc + 20;
      sb.push_back(e);
      key        = rnd128();
      cyphertext = rnd128();
   endtask

   task automatic wait_done();
      for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
      if (sb.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL timeout: %0d results pending after 40 cycles, required 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin : driver
      int t0, hi;
      logic [127:0] k, p;
      build_tables();
      key        = rnd128();
      cyphertext = rnd128();
      repeat (2) @(negedge clk);
      chk128("reset_plaintext", plaintext, '0);
      chkint("reset_done", int'(done), 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chkint("idle_done", int'(done), 0);

      start_run(K1, C1, P1, 1);
      wait_done();

      start_run(K2, C2, P2, 2);
      wait_done();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chkint("done_hold", int'(done), 1);
         chk128("plaintext_hold", plaintext, P2);
      end

      // abort with B vectors in flight, restart with C.1
      start_run(K2, C2, P2, 1);
      t0 = cyc;
      while (cyc < t0 + 6) @(negedge clk);
      sb.delete(sb.size() - 1);
      start_run(K1, C1, P1, 1);
      wait_done();

      // asynchronous reset between edges after E12
      start_run(K2, C2, P2, 1);
      t0 = cyc;
      while (cyc < t0 + 12) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chkint("rst_done", int'(done), 0);
      chk128("rst_plaintext", plaintext, '0);
      #1 rst = 1'b0;
      sb.delete(sb.size() - 1);
      hi = 0;
      repeat (30) begin
         @(negedge clk);
         if (done) hi++;
      end
      chkint("no_done_after_rst", hi, 0);

      for (int i = 0; i < 8; i++) begin
         k = rnd128();
         p = rnd128();
         start_run(k, aes_enc(p, k), p, 1 + int'($urandom_range(0, 2)));
         wait_done();
      end

      for (int i = 0; i < 4; i++) begin
         k = rnd128();
         p = rnd128();
         start_run(k, p, aes_dec(p, k), 1);
         wait_done();
      end

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule

// File: doc/aes_inv_core.md
AES_INV_CORE -- requirements
Module: aes_inv_core

Interface
REQ-001 Parameters: none; AES-128 only (Nk=4, Nr=10).
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-high.
REQ-004 load  input  1  high = capture key and cyphertext; falling edge starts decryption.
REQ-005 key  input  128  cipher key, byte 0 in bits [127:120] (FIPS-197 order).
REQ-006 cyphertext  input  128  block to decrypt, same byte order.
REQ-007 done  output  1  high = plaintext valid.
REQ-008 plaintext  output  128  decrypted block, same byte order.

Function
REQ-009 The FSM SHALL use the states IDLE, CAPTURE, KEYEXP, ROUND and DONE.
REQ-010 In any state, each rising edge with load=1 SHALL register key and cyphertext, enter CAPTURE and set done=0.
REQ-011 In CAPTURE, the first edge with load=0 (edge E1) SHALL enter KEYEXP and compute round key 1 from the captured key using the forward schedule (RotWord, SubWord, Rcon).
REQ-012 Edges E1..E10 SHALL each advance the forward schedule one round, holding only the current round key (no 11-key storage).
REQ-013 At E10 the block SHALL also load data_state <= cyphertext XOR rk10 and enter ROUND with round counter 9.
REQ-014 Each ROUND edge (E11..E20) SHALL derive rk(r) from rk(r+1) by the inverse key schedule, with Rcon(r+1) applied to word 0.
REQ-015 Each ROUND edge SHALL apply InvShiftRows, then InvSubBytes, then AddRoundKey(rk(r)).
REQ-016 Each ROUND edge SHALL then apply InvMixColumns when r>0 and skip it when r=0.
REQ-017 At E20 (r=0) the block SHALL register the result on plaintext, set done=1 and enter DONE.
REQ-018 Total latency SHALL be exactly 20 rising edges from E1 to done=1 being observable.
REQ-019 In DONE, done and plaintext SHALL hold until the next edge with load=1 or until rst.
REQ-020 In IDLE with load=0, the block SHALL stay idle, done SHALL remain 0 and plaintext SHALL hold.
REQ-021 load=1 during KEYEXP or ROUND SHALL abort the run, recapture the inputs, and restart the full 20-cycle sequence from the next falling edge of load.
REQ-022 key and cyphertext SHALL be ignored except on edges with load=1; input changes after the load falling edge SHALL NOT affect the result.
REQ-023 GF(2^8) arithmetic SHALL use polynomial 0x11B; InvMixColumns multiplies by 0x0E, 0x0B, 0x0D and 0x09.
REQ-024 Rcon SHALL be 01,02,04,08,10,20,40,80,1B,36 for rounds 1..10.

Reset
REQ-025 While rst=1, independent of clk, the block SHALL force state=IDLE, done=0, plaintext=0, round counter=0, and clear the captured key/data registers.
REQ-026 Reset asserted mid-operation SHALL discard the run; after rst falls, no operation SHALL start until load is asserted.

Structure
REQ-027 Shared package aes_pkg SHALL hold the state enum, the Nr=10 constant, the Rcon table and the GF(2^8) xtime/multiply functions.
REQ-028 The forward sbox used by aes_core SHALL be reused for the key schedule.
REQ-029 One new combinational sub-module, aes_inv_sbox (byte in, byte out), SHALL be instantiated 16 times for InvSubBytes.
REQ-030 The datapath SHALL be iterative: one round instance, with no unrolling of rounds.

Verification
REQ-031 Bench SHALL cover: key 000102030405060708090A0B0C0D0E0F, cyphertext 69C4E0D86A7B0430D8CDB78070B4C55A -> plaintext 00112233445566778899AABBCCDDEEFF.
REQ-032 Bench SHALL cover: key 2B7E151628AED2A6ABF7158809CF4F3C, cyphertext 3925841D02DC09FBDC118597196A0B32 -> plaintext 3243F6A8885A308D313198A2E0370734.
REQ-033 Bench SHALL cover: load held 2 cycles then dropped -> done=0 through E19 and done=1 exactly at E20; done stays 1 for 5 further idle cycles.
REQ-034 Bench SHALL cover: rst pulsed between clock edges at E12 -> done=0 and plaintext=0 immediately; no done for 30 cycles without load.
REQ-035 Bench SHALL cover: load reasserted at E7 with the C.1 vectors after starting with the B vectors -> done only at E20 of the new run, with the C.1 plaintext.
REQ-036 Bench SHALL cover: round trip, aes_core output fed into aes_inv_core with the same key for 8 random key/block pairs -> the original plaintext is recovered every time.
